pes_serdes_shift: RTL and testbench
===================================

Name: pes_serdes_shift

Overview:
- Parametrised successor to the team's 4-bit serial-in/serial-out shift register.
- Contains an independent transmit serialiser and receive deserialiser, both WIDTH bits wide, with selectable bit order (LSB-first or MSB-first) and a shift-enable strobe.
- The transmit side takes words through a valid/ready handshake. The receive side emits a one-cycle valid pulse per assembled word.
- Sits between parallel datapath logic and a bit-serial link or a loopback test path.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- IDLE_LEVEL, 0, value driven on serial_out when no word is being sent.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  shift strobe; TX and RX advance one bit only on cycles with en=1.
- dir  in  1  bit order: 0 = LSB-first, 1 = MSB-first.
- tx_data  in  WIDTH  parallel word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX is idle and accepts a word.
- tx_busy  out  1  TX word in progress.
- tx_done  out  1  one-cycle pulse when the last bit of a word has been driven.
- serial_out  out  1  registered serial output.
- serial_in  in  1  serial input.
- rx_en  in  1  RX capture enable.
- rx_clear  in  1  synchronous abort of a partial RX word.
- rx_data  out  WIDTH  last assembled word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_perr  out  1  parity error flag, qualified by rx_valid.

Behaviour:
- Reset values (reset_n=0, asynchronous):
  - TX FSM = IDLE; tx_ready=1, tx_busy=0, tx_done=0, serial_out=IDLE_LEVEL.
  - All shift registers and counters = 0.
  - rx_data=0, rx_valid=0, rx_perr=0.
- TX FSM states: IDLE, SHIFT, PARITY. PARITY exists only when the optional feature is compiled in.
- IDLE:
  - tx_ready=1 and serial_out=IDLE_LEVEL.
  - tx_valid=1 loads tx_data into the TX shift register, latches dir, clears the bit counter and moves to SHIFT next cycle.
  - Loading happens regardless of en.
- SHIFT:
  - tx_ready=0, tx_busy=1.
  - On each en=1 cycle: serial_out <= next bit (bit0 if latched dir=0, bit WIDTH-1 if dir=1), the register shifts toward that end, counter+1.
  - en=0 holds serial_out, the register and the counter.
- End of word: the en=1 cycle with counter==WIDTH-1 drives the final bit. Next state is IDLE (or PARITY), with a tx_done pulse the same cycle the FSM leaves SHIFT.
- The last data bit stays on serial_out until the next en=1 cycle, or until IDLE forces IDLE_LEVEL on the cycle after leaving SHIFT.
- Back-to-back words need at least one IDLE cycle; tx_valid during SHIFT/PARITY is ignored and not stored.
- A change of dir mid-word has no effect on the word in flight.
- RX capture:
  - On en=1 and rx_en=1, serial_in is inserted.
  - dir=0: insert at MSB, shift right, so the first received bit ends at bit0.
  - dir=1: insert at LSB, shift left, so the first received bit ends at bit WIDTH-1.
  - dir is sampled on the first bit of each word and held for that word.
- RX word complete: on the WIDTH-th captured bit, rx_data <= the assembled word (including that bit), rx_valid=1 for one cycle, and the counter wraps to 0. The next word can start on the very next en cycle.
- rx_clear=1 zeroes the RX counter and shift register. It has priority over a simultaneous capture, no rx_valid is generated, and rx_data holds its value.
- TX and RX are fully independent. Loopback (serial_out to serial_in) with matching dir reproduces tx_data.
- Asynchronous reset mid-word aborts both sides immediately with no tx_done/rx_valid. After reset release the block is in IDLE.

Optional Feature:
- Macro: PES_SERDES_PARITY_EN.
- Defined:
  - After the WIDTH data bits, TX enters PARITY and on the next en=1 cycle drives even parity (XOR of the data) on serial_out. tx_done pulses when leaving PARITY.
  - RX collects WIDTH+1 bits. On the last bit, rx_valid pulses and rx_perr = (XOR of data) XOR (received parity bit).
- Undefined: no PARITY state, words are exactly WIDTH bits, and rx_perr is tied to 0.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release, 5 idle cycles -> tx_ready=1, serial_out=0, rx_valid=0 throughout.
- TX LSB-first, WIDTH=8, en held high: dir=0, tx_data=0xA5 -> serial_out sequence 1,0,1,0,0,1,0,1 on consecutive cycles; tx_done pulses once; tx_ready returns to 1 one cycle later.
- TX MSB-first with en gaps: dir=1, tx_data=0x3C, en toggling 1/0 -> serial_out bits 0,0,1,1,1,1,0,0 each held across the en=0 cycles; tx_done only after the 8th en; tx_valid during the word is ignored.
- Loopback: serial_out to serial_in, rx_en=1, words 0x00, 0xFF, 0x5A in both dir settings -> rx_data equals each word, exactly one rx_valid per word, rx_perr=0.
- RX abort and reset: 3 bits captured, then rx_clear -> no rx_valid, rx_data unchanged, next 8 bits give a correct word. Separately, reset_n asserted after 4 TX bits -> serial_out=0, tx_ready=1 immediately, no tx_done.
- Parity (with the macro defined): send 0x07 -> parity bit 1 follows the data; then inject a flipped parity bit on serial_in -> rx_valid with rx_perr=1.

Source files
------------

// File: rtl/pes_serdes_shift.sv
// pes_serdes_shift: independent WIDTH-bit TX serialiser / RX deserialiser with LSB- or MSB-first order.
// Define PES_SERDES_PARITY_EN to append an even-parity bit per word on TX and check it on RX.
module pes_serdes_shift #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             serial_out,
    input  logic             serial_in,
    input  logic             rx_en,
    input  logic             rx_clear,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_perr
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef PES_SERDES_PARITY_EN
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
`ifdef PES_SERDES_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_dir_q, tx_dir_d;
    logic             serial_out_q, serial_out_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
`ifdef PES_SERDES_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_dir_q, rx_dir_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_perr_q, rx_perr_d;
    logic             rx_dir_eff;
    logic [WIDTH-1:0] rx_ins;

    // TX state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tx_sh_q      <= '0;
            tx_cnt_q     <= '0;
            tx_dir_q     <= 1'b0;
            serial_out_q <= IDLE_LEVEL;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
`ifdef PES_SERDES_PARITY_EN
            tx_par_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_sh_q      <= tx_sh_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_dir_q     <= tx_dir_d;
            serial_out_q <= serial_out_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
`ifdef PES_SERDES_PARITY_EN
            tx_par_q     <= tx_par_d;
`endif
        end
    end

    // TX next state; ready reasserts one cycle after the word ends so IDLE sees a full cycle
    always_comb begin
        state_d      = state_q;
        tx_sh_d      = tx_sh_q;
        tx_cnt_d     = tx_cnt_q;
        tx_dir_d     = tx_dir_q;
        serial_out_d = serial_out_q;
        tx_ready_d   = tx_ready_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;
`ifdef PES_SERDES_PARITY_EN
        tx_par_d     = tx_par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                serial_out_d = IDLE_LEVEL;
                tx_ready_d   = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    state_d    = ST_SHIFT;
                    tx_sh_d    = tx_data;
                    tx_dir_d   = dir;
                    tx_cnt_d   = '0;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
`ifdef PES_SERDES_PARITY_EN
                    tx_par_d   = ^tx_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (tx_dir_q) begin
                        serial_out_d = tx_sh_q[WIDTH-1];
                        tx_sh_d      = tx_sh_q << 1;
                    end else begin
                        serial_out_d = tx_sh_q[0];
                        tx_sh_d      = tx_sh_q >> 1;
                    end
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == LAST_BIT) begin
                        tx_cnt_d  = '0;
`ifdef PES_SERDES_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_IDLE;
                        tx_busy_d = 1'b0;
                        tx_done_d = 1'b1;
`endif
                    end
                end
            end
`ifdef PES_SERDES_PARITY_EN
            ST_PARITY: begin
                if (en) begin
                    serial_out_d = tx_par_q;
                    state_d      = ST_IDLE;
                    tx_busy_d    = 1'b0;
                    tx_done_d    = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // RX registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_dir_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_dir_q   <= rx_dir_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // RX capture; bit order is fixed by dir at the first bit of each word
    always_comb begin
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_dir_d   = rx_dir_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_dir_eff = (rx_cnt_q == '0) ? dir : rx_dir_q;
        rx_ins     = rx_dir_eff ? {rx_sh_q[WIDTH-2:0], serial_in}
                                : {serial_in, rx_sh_q[WIDTH-1:1]};
        if (rx_clear) begin
            rx_cnt_d = '0;
            rx_sh_d  = '0;
        end else if (en && rx_en) begin
            rx_dir_d = rx_dir_eff;
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            if (rx_cnt_q == RX_LAST) begin
                rx_cnt_d   = '0;
                rx_sh_d    = '0;
                rx_valid_d = 1'b1;
`ifdef PES_SERDES_PARITY_EN
                rx_data_d  = rx_sh_q;
                rx_perr_d  = (^rx_sh_q) ^ serial_in;
`else
                rx_data_d  = rx_ins;
                rx_perr_d  = 1'b0;
`endif
            end else begin
                rx_sh_d = rx_ins;
            end
        end
    end

    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign serial_out = serial_out_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_perr    = rx_perr_q;

endmodule

// File: tb/tb_pes_serdes_shift.sv
// Scoreboard bench for pes_serdes_shift: stimulus queues expected TX bits / RX words, monitor compares.
`timescale 1ns/1ps
module tb_pes_serdes_shift;
    localparam int unsigned WIDTH = 8;
`ifdef PES_SERDES_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif

    typedef struct packed { logic b; logic last; } txexp_t;
    typedef struct packed { logic [WIDTH-1:0] data; logic perr; } rxexp_t;

    logic             clk = 1'b0;
    logic             reset_n, en, dir, tx_valid, rx_en, rx_clear;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready, tx_busy, tx_done, serial_out, serial_in;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid, rx_perr;
    logic             sin_drv, loop_mode;
    int               en_mode;
    int               n_vec = 0, n_err = 0;
    int               done_seen = 0, done_exp = 0;
    txexp_t           txq[$];
    rxexp_t           rxq[$];
    logic             pv_bit = 1'b0, pv_hold = 1'b0, pv_ready = 1'b0, last_out = 1'b0;

    assign serial_in = loop_mode ? serial_out : sin_drv;

    pes_serdes_shift #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_done(tx_done), .serial_out(serial_out),
        .serial_in(serial_in), .rx_en(rx_en), .rx_clear(rx_clear),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a bit is driven at every edge that sees tx_busy && en; compare it one half-cycle later
    always @(negedge clk) begin
        if (!reset_n) begin
            pv_bit   <= 1'b0;
            pv_hold  <= 1'b0;
            pv_ready <= 1'b0;
        end else begin
            if (pv_bit) begin
                if (txq.size() == 0) check("tx_unexpected_bit", 32'(1), 32'(0));
                else begin
                    check("tx_bit", 32'(serial_out), 32'(txq[0].b));
                    check("tx_done_timing", 32'(tx_done), 32'(txq[0].last));
                    txq.delete(0);
                end
            end else if (pv_hold) begin
                check("tx_hold", 32'(serial_out), 32'(last_out));
            end else if (pv_ready) begin
                check("tx_idle_level", 32'(serial_out), 32'(0));
            end
            if (tx_done) done_seen++;
            if (rx_valid) begin
                if (rxq.size() == 0) check("rx_unexpected_valid", 32'(1), 32'(0));
                else begin
                    check("rx_data", 32'(rx_data), 32'(rxq[0].data));
                    check("rx_perr", 32'(rx_perr), 32'(rxq[0].perr));
                    rxq.delete(0);
                end
            end
            pv_bit   <= tx_busy && en;
            pv_hold  <= tx_busy && !en;
            pv_ready <= tx_ready;
            last_out <= serial_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (en_mode)
            0:       en = 1'b0;
            1:       en = 1'b1;
            default: en = ~en;
        endcase
    endtask

    task automatic send_issue(input logic [WIDTH-1:0] w, input logic d);
        txexp_t e;
        int     k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 100) begin tick(); k++; end
        check("tx_ready_before_issue", 32'(tx_ready), 32'(1));
        for (int i = 0; i < WIDTH; i++) begin
            e.b = d ? w[WIDTH-1-i] : w[i];
`ifdef PES_SERDES_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == WIDTH - 1);
`endif
            txq.push_back(e);
        end
`ifdef PES_SERDES_PARITY_EN
        e.b = ^w;
        e.last = 1'b1;
        txq.push_back(e);
`endif
        done_exp++;
        tx_data  = w;
        dir      = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_done();
        int k;
        k = 0;
        while (tx_done !== 1'b1 && k < 200) begin tick(); k++; end
        if (k >= 200) check("tx_done_timeout", 32'(0), 32'(1));
        else begin
            check("tx_ready_during_done", 32'(tx_ready), 32'(0));
            tick();
            check("tx_ready_after_done", 32'(tx_ready), 32'(1));
        end
    endtask

    // Loopback: bit k leaves TX at edge k and is captured at edge k+1 (en held high)
    task automatic loop_word(input logic [WIDTH-1:0] w, input logic d);
        rxexp_t r;
        r.data = w;
        r.perr = 1'b0;
        rxq.push_back(r);
        send_issue(w, d);
        tick();
        rx_en = 1'b1;
        for (int i = 0; i < NB; i++) tick();
        rx_en = 1'b0;
        check("lb_tx_ready", 32'(tx_ready), 32'(1));
    endtask

    task automatic rx_word(input logic [WIDTH-1:0] w, input logic d, input logic flip);
        logic [WIDTH:0] seq;
        for (int i = 0; i < WIDTH; i++) seq[i] = d ? w[WIDTH-1-i] : w[i];
        seq[WIDTH] = (^w) ^ flip;
        dir   = d;
        rx_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            sin_drv = seq[i];
            tick();
        end
        rx_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rxexp_t r;
        reset_n = 1'b0; en = 1'b0; dir = 1'b0; tx_valid = 1'b0; tx_data = '0;
        rx_en = 1'b0; rx_clear = 1'b0; sin_drv = 1'b0; loop_mode = 1'b0; en_mode = 1;

        // reset then idle
        repeat (3) tick();
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        check("rst_tx_busy", 32'(tx_busy), 32'(0));
        check("rst_serial_out", 32'(serial_out), 32'(0));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_tx_ready", 32'(tx_ready), 32'(1));
            check("idle_serial_out", 32'(serial_out), 32'(0));
            check("idle_rx_valid", 32'(rx_valid), 32'(0));
        end

        // TX LSB-first 0xA5, en high: 1,0,1,0,0,1,0,1
        send_issue(8'hA5, 1'b0);
        wait_tx_done();
        repeat (2) tick();

        // TX MSB-first 0x3C with en toggling; mid-word tx_valid and dir change are ignored
        en_mode = 2;
        send_issue(8'h3C, 1'b1);
        repeat (3) tick();
        tx_valid = 1'b1; tx_data = 8'hFF; dir = 1'b0;
        repeat (2) tick();
        tx_valid = 1'b0;
        wait_tx_done();
        en_mode = 1;
        repeat (2) tick();

        // loopback in both bit orders
        loop_mode = 1'b1;
        loop_word(8'h00, 1'b0);
        loop_word(8'hFF, 1'b0);
        loop_word(8'h5A, 1'b0);
        loop_word(8'h00, 1'b1);
        loop_word(8'hFF, 1'b1);
        loop_word(8'h5A, 1'b1);
        loop_mode = 1'b0;
        repeat (2) tick();

        // RX abort: 3 bits, clear (with a simultaneous capture), then a full word 0xC3
        dir = 1'b0; rx_en = 1'b1;
        sin_drv = 1'b1; tick();
        sin_drv = 1'b0; tick();
        sin_drv = 1'b1; tick();
        rx_clear = 1'b1; tick();
        rx_clear = 1'b0; rx_en = 1'b0;
        tick();
        check("rx_data_held_after_clear", 32'(rx_data), 32'(8'h5A));
        r.data = 8'hC3; r.perr = 1'b0;
        rxq.push_back(r);
        rx_word(8'hC3, 1'b0, 1'b0);
        repeat (2) tick();

        // reset mid-TX after 4 bits
        send_issue(8'h96, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_serial_out", 32'(serial_out), 32'(0));
        check("abort_tx_ready", 32'(tx_ready), 32'(1));
        check("abort_tx_busy", 32'(tx_busy), 32'(0));
        check("abort_tx_done", 32'(tx_done), 32'(0));
        check("abort_rx_data", 32'(rx_data), 32'(0));
        txq.delete();
        done_exp--;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_reset_tx_ready", 32'(tx_ready), 32'(1));

`ifdef PES_SERDES_PARITY_EN
        // parity: 0x07 has odd weight so the parity bit is 1; then a flipped parity bit on RX
        send_issue(8'h07, 1'b0);
        wait_tx_done();
        repeat (2) tick();
        r.data = 8'h07; r.perr = 1'b1;
        rxq.push_back(r);
        rx_word(8'h07, 1'b0, 1'b1);
        repeat (2) tick();
`endif

        repeat (3) tick();
        check("txq_drained", 32'(txq.size()), 32'(0));
        check("rxq_drained", 32'(rxq.size()), 32'(0));
        check("tx_done_count", 32'(done_seen), 32'(done_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
